pipeline_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage MIPS-32 pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Drives per-register write-enable and flush (bubble) controls, and the PC write enable.
- Detects load-use hazards and acts on taken branches resolved in MEM.
- Freezes the pipeline for a multicycle data-memory access.
- Keeps saturating stall and flush performance counters.

---
 rtl/mips_pipe_pkg.sv | 15 +
 rtl/load_use_detect.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS-32 pipeline hazard controller.
package mips_pipe_pkg;

  // Register-specifier width and the hard-wired zero register.
  localparam int              REG_W    = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  // Hazard sequencer state encoding, exported as-is on the State port.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load sitting in ID/EX whose
// destination feeds a source operand of the instruction in ID.
module load_use_detect
  import mips_pipe_pkg::*;
(
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rt_i,
  output logic             lu_o
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rt_i == id_rs_i);
  // rt only matters when the ID instruction actually reads it as a source.
  assign rt_match = id_uses_rt_i && (ex_rt_i == id_rt_i);
  // Writes to $zero never create a dependency.
  assign lu_o     = ex_mem_read_i && (ex_rt_i != ZERO_REG) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline registers: load-use
// bubbles, taken-branch flushes, multicycle data-memory freeze and
// saturating performance counters.
module pipeline_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ID_RS,
  input  logic [REG_W-1:0] ID_RT,
  input  logic             ID_UsesRT,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_RT,
  input  logic             MEM_Access,
  input  logic             MEM_BranchTaken,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Write,
  output logic             IDEX_Flush,
  output logic             EXMEM_Write,
  output logic             EXMEM_Flush,
  output logic             MEMWB_Flush,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  // Wait counter only needs to hold MEM_WAIT-1.
  localparam int              WC_W      = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [WC_W-1:0] WAIT_LOAD = (MEM_WAIT > 0) ? WC_W'(MEM_WAIT - 1) : '0;
  localparam logic            HAS_WAIT  = (MEM_WAIT > 0);

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q, flush_q;
  logic              lu;
  logic              freeze_entry;
  logic              frozen;

  load_use_detect u_lu (
    .id_rs_i       (ID_RS),
    .id_rt_i       (ID_RT),
    .id_uses_rt_i  (ID_UsesRT),
    .ex_mem_read_i (EX_MemRead),
    .ex_rt_i       (EX_RT),
    .lu_o          (lu)
  );

  // RELEASE treats the held access as served, so only RUN can start a freeze.
  assign freeze_entry = (state_q == RUN) && MEM_Access && HAS_WAIT;
  assign frozen       = freeze_entry || (state_q == WAIT);

  // Next-state and wait-counter logic for the memory freeze sequence.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN: begin
        if (freeze_entry) begin
          state_d = WAIT;
          wait_d  = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (wait_q == '0) begin
          state_d = RELEASE;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      RELEASE: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Same-cycle pipeline controls: reset, then freeze, then branch, then load-use.
  always_comb begin
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Write  = 1'b1;
    IDEX_Flush  = 1'b0;
    EXMEM_Write = 1'b1;
    EXMEM_Flush = 1'b0;
    MEMWB_Flush = 1'b0;
    if (reset) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Write  = 1'b0;
      EXMEM_Write = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
      MEMWB_Flush = 1'b1;
    end else if (frozen) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Write  = 1'b0;
      EXMEM_Write = 1'b0;
      MEMWB_Flush = 1'b1;
    end else if (MEM_BranchTaken) begin
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
    end else if (lu) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Flush  = 1'b1;
    end
  end

  // State register and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Saturating stall-cycle and branch-flush counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!PCWrite && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (!frozen && MEM_BranchTaken && (flush_q != '1)) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign State       = state_q;
  assign StallCycles = stall_q;
  assign FlushCount  = flush_q;

endmodule
